// File: rtl/trig_stream_pkg.sv
// trig_stream_pkg: shared tags, FSM state type and sequence width for the trigger stream receiver.
package trig_stream_pkg;

    localparam int SEQ_BITS = 16;

    localparam logic [1:0] TAG_HDR  = 2'b10;
    localparam logic [1:0] TAG_MASK = 2'b01;

    typedef enum logic {
        HDR,
        MSK
    } state_t;

endpackage

// File: rtl/trig_stream_receiver_sat_counter.sv
// sat_counter: counter that sticks at all-ones instead of wrapping.
// Ports:
//   ifclk  - clock
//   clr_i  - synchronous clear, wins over inc_i
//   inc_i  - add one unless already saturated
//   cnt_o  - current count
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             ifclk,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge ifclk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/trig_stream_receiver.sv
// trig_stream_receiver: AXI4-Stream sink that frames header/mask trigger records into events.
// Ports:
//   ifclk, ifclk_rst_i       - clock and synchronous active-high reset
//   runrst_i                 - run reset: clears counters and sequence tracking
//   s_trig_*                 - 32-bit trigger word stream (tag in [31:30])
//   evt_valid_o/evt_ready_i  - registered event handshake
//   evt_seq_o, evt_mask_o    - decoded event payload
//   evt_count_o              - saturating count of delivered events
//   err_frame_o, err_seq_o   - saturating framing / sequence-gap error counts
module trig_stream_receiver
    import trig_stream_pkg::*;
#(
    parameter int NBEAMS   = 2,
    parameter int CNT_BITS = 16
) (
    input  logic                ifclk,
    input  logic                ifclk_rst_i,
    input  logic                runrst_i,
    input  logic [31:0]         s_trig_tdata,
    input  logic                s_trig_tvalid,
    output logic                s_trig_tready,
    output logic                evt_valid_o,
    input  logic                evt_ready_i,
    output logic [15:0]         evt_seq_o,
    output logic [NBEAMS-1:0]   evt_mask_o,
    output logic [31:0]         evt_count_o,
    output logic [CNT_BITS-1:0] err_frame_o,
    output logic [CNT_BITS-1:0] err_seq_o
);

    state_t              state_q, state_d;
    logic [SEQ_BITS-1:0] seq_q, seq_d;
    logic [SEQ_BITS-1:0] exp_q, exp_d;
    logic                known_q, known_d;
    logic                evt_valid_q, evt_valid_d;
    logic [SEQ_BITS-1:0] evt_seq_q, evt_seq_d;
    logic [NBEAMS-1:0]   evt_mask_q, evt_mask_d;

    logic [1:0]          tag;
    logic [SEQ_BITS-1:0] word_seq;
    logic                acc;
    logic                hdr_acc;
    logic                load;
    logic                frame_err;
    logic                seq_err;
    logic                evt_hs;
    logic                clr;
    logic                unused_bits;

    // Header words carry nothing in [29:16].
    assign unused_bits = ^s_trig_tdata[29:16];

    // tready depends only on state, resets and evt_ready_i, never on tvalid.
    // In MSK it stalls while a delivered event is still waiting, so a mask
    // can only be accepted when the output register is free to reload.
    assign s_trig_tready = !ifclk_rst_i && !runrst_i &&
                           (state_q == HDR || !evt_valid_q || evt_ready_i);

    always_comb begin
        tag       = s_trig_tdata[31:30];
        word_seq  = s_trig_tdata[SEQ_BITS-1:0];
        acc       = s_trig_tvalid && s_trig_tready;
        hdr_acc   = acc && tag == TAG_HDR;
        load      = acc && state_q == MSK && tag == TAG_MASK;
        frame_err = acc && !(state_q == HDR ? tag == TAG_HDR : tag == TAG_MASK);
        seq_err   = hdr_acc && known_q && word_seq != exp_q;
        evt_hs    = evt_valid_q && evt_ready_i;
        clr       = ifclk_rst_i || runrst_i;
        // A header in either state (re)starts a record; anything else ends in HDR.
        state_d     = runrst_i ? HDR : acc ? (tag == TAG_HDR ? MSK : HDR) : state_q;
        seq_d       = hdr_acc ? word_seq : seq_q;
        exp_d       = hdr_acc ? word_seq + 1'b1 : exp_q;
        known_d     = !runrst_i && (known_q || hdr_acc);
        // Reload wins over the handshake clear in the same cycle.
        evt_valid_d = load || (evt_valid_q && !evt_ready_i);
        evt_seq_d   = load ? seq_q : evt_seq_q;
        evt_mask_d  = load ? s_trig_tdata[NBEAMS-1:0] : evt_mask_q;
    end

    always_ff @(posedge ifclk) begin
        if (ifclk_rst_i) begin
            state_q     <= HDR;
            seq_q       <= '0;
            exp_q       <= '0;
            known_q     <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_seq_q   <= '0;
            evt_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            exp_q       <= exp_d;
            known_q     <= known_d;
            evt_valid_q <= evt_valid_d;
            evt_seq_q   <= evt_seq_d;
            evt_mask_q  <= evt_mask_d;
        end
    end

    assign evt_valid_o = evt_valid_q;
    assign evt_seq_o   = evt_seq_q;
    assign evt_mask_o  = evt_mask_q;

    // clr dominates inc, so a handshake coinciding with runrst_i is not counted.
    sat_counter #(.WIDTH(32)) u_evt_cnt (
        .ifclk (ifclk),
        .clr_i (clr),
        .inc_i (evt_hs),
        .cnt_o (evt_count_o)
    );

    sat_counter #(.WIDTH(CNT_BITS)) u_frame_cnt (
        .ifclk (ifclk),
        .clr_i (clr),
        .inc_i (frame_err),
        .cnt_o (err_frame_o)
    );

    sat_counter #(.WIDTH(CNT_BITS)) u_seq_cnt (
        .ifclk (ifclk),
        .clr_i (clr),
        .inc_i (seq_err),
        .cnt_o (err_seq_o)
    );

endmodule

// File: tb/tb_trig_stream_receiver.sv
// tb_trig_stream_receiver: directed table and sequence checks for trig_stream_receiver.
module tb_trig_stream_receiver;

    localparam int NB = 2;
    localparam int CB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          runrst;
    logic [31:0]   tdata;
    logic          tvalid;
    logic          tready;
    logic          evt_valid;
    logic          evt_ready;
    logic [15:0]   evt_seq;
    logic [NB-1:0] evt_mask;
    logic [31:0]   evt_count;
    logic [CB-1:0] err_frame;
    logic [CB-1:0] err_seq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trig_stream_receiver #(.NBEAMS(NB), .CNT_BITS(CB)) dut (
        .ifclk         (clk),
        .ifclk_rst_i   (rst),
        .runrst_i      (runrst),
        .s_trig_tdata  (tdata),
        .s_trig_tvalid (tvalid),
        .s_trig_tready (tready),
        .evt_valid_o   (evt_valid),
        .evt_ready_i   (evt_ready),
        .evt_seq_o     (evt_seq),
        .evt_mask_o    (evt_mask),
        .evt_count_o   (evt_count),
        .err_frame_o   (err_frame),
        .err_seq_o     (err_seq)
    );

    typedef struct {
        logic [31:0] d;
        logic        v;
        logic        rr;
        logic        tr;
        logic        ev;
        logic [15:0] sq;
        logic [1:0]  m;
        int          c;
        int          es;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [31:0] hw(input logic [15:0] s);
        return {2'b10, 14'h0, s};
    endfunction

    function automatic logic [31:0] mw(input logic [1:0] m);
        return {2'b01, 28'h0, m};
    endfunction

    function automatic vec_t mk(input logic [31:0] d, input logic v, input logic rr,
                                input logic tr, input logic ev, input logic [15:0] sq,
                                input logic [1:0] m, input int c, input int es);
        vec_t r;
        r.d = d; r.v = v; r.rr = rr; r.tr = tr; r.ev = ev;
        r.sq = sq; r.m = m; r.c = c; r.es = es;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic v, input logic rdy, input logic rr);
        tdata = d;
        tvalid = v;
        evt_ready = rdy;
        runrst = rr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        runrst = 1'b0;
        tdata = '0;
        tvalid = 1'b0;
        evt_ready = 1'b1;

        tbl[0]  = mk(hw(16'h0005), 1, 0, 1, 0, 16'h0000, 2'b00, 0, 0);
        tbl[1]  = mk(mw(2'b10),    1, 0, 1, 0, 16'h0000, 2'b00, 0, 0);
        tbl[2]  = mk(hw(16'h0006), 1, 0, 1, 1, 16'h0005, 2'b10, 0, 0);
        tbl[3]  = mk(mw(2'b01),    1, 0, 1, 0, 16'h0005, 2'b10, 1, 0);
        tbl[4]  = mk(32'h0,        0, 0, 1, 1, 16'h0006, 2'b01, 1, 0);
        tbl[5]  = mk(32'h0,        0, 0, 1, 0, 16'h0006, 2'b01, 2, 0);
        tbl[6]  = mk(hw(16'h1234), 1, 1, 0, 0, 16'h0006, 2'b01, 2, 0);
        tbl[7]  = mk(hw(16'hFFFE), 1, 0, 1, 0, 16'h0006, 2'b01, 0, 0);
        tbl[8]  = mk(mw(2'b01),    1, 0, 1, 0, 16'h0006, 2'b01, 0, 0);
        tbl[9]  = mk(hw(16'hFFFF), 1, 0, 1, 1, 16'hFFFE, 2'b01, 0, 0);
        tbl[10] = mk(mw(2'b10),    1, 0, 1, 0, 16'hFFFE, 2'b01, 1, 0);
        tbl[11] = mk(hw(16'h0000), 1, 0, 1, 1, 16'hFFFF, 2'b10, 1, 0);
        tbl[12] = mk(mw(2'b11),    1, 0, 1, 0, 16'hFFFF, 2'b10, 2, 0);
        tbl[13] = mk(hw(16'h0003), 1, 0, 1, 1, 16'h0000, 2'b11, 2, 0);
        tbl[14] = mk(mw(2'b01),    1, 0, 1, 0, 16'h0000, 2'b11, 3, 1);
        tbl[15] = mk(32'h0,        0, 0, 1, 1, 16'h0003, 2'b01, 3, 1);
        tbl[16] = mk(32'h0,        0, 0, 1, 0, 16'h0003, 2'b01, 4, 1);

        // Reset: tready low while held, then everything cleared.
        @(negedge clk);
        drive(hw(16'h0001), 1, 1, 0);
        chk("rst_tready", {31'h0, tready}, 32'h0);
        tick();
        rst = 1'b0;
        drive(32'h0, 0, 1, 0);
        chk("rst_valid", {31'h0, evt_valid}, 32'h0);
        chk("rst_seq", {16'h0, evt_seq}, 32'h0);
        chk("rst_mask", {30'h0, evt_mask}, 32'h0);
        chk("rst_cnt", evt_count, 32'h0);
        chk("rst_ef", {28'h0, err_frame}, 32'h0);
        chk("rst_es", {28'h0, err_seq}, 32'h0);
        chk("rst_tready_hi", {31'h0, tready}, 32'h1);

        // Back-to-back records, runrst, then wrap and a sequence gap.
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].d, tbl[i].v, 1'b1, tbl[i].rr);
            chk($sformatf("t%0d_tready", i), {31'h0, tready}, {31'h0, tbl[i].tr});
            chk($sformatf("t%0d_valid", i), {31'h0, evt_valid}, {31'h0, tbl[i].ev});
            chk($sformatf("t%0d_seq", i), {16'h0, evt_seq}, {16'h0, tbl[i].sq});
            chk($sformatf("t%0d_mask", i), {30'h0, evt_mask}, {30'h0, tbl[i].m});
            chk($sformatf("t%0d_cnt", i), evt_count, tbl[i].c);
            chk($sformatf("t%0d_es", i), {28'h0, err_seq}, tbl[i].es);
            chk($sformatf("t%0d_ef", i), {28'h0, err_frame}, 32'h0);
            tick();
        end

        // Framing errors: stray mask, header resync, illegal tag in MSK.
        drive(32'h0, 0, 1, 1); tick();
        drive(mw(2'b10), 1, 1, 0); tick();
        drive(hw(16'h0010), 1, 1, 0); tick();
        drive(hw(16'h0011), 1, 1, 0); tick();
        drive(mw(2'b11), 1, 1, 0); tick();
        drive(32'h0, 0, 1, 0);
        chk("fr_valid", {31'h0, evt_valid}, 32'h1);
        chk("fr_seq", {16'h0, evt_seq}, 32'h11);
        chk("fr_mask", {30'h0, evt_mask}, 32'h3);
        chk("fr_ef", {28'h0, err_frame}, 32'h2);
        chk("fr_es", {28'h0, err_seq}, 32'h0);
        tick();
        chk("fr_valid_clr", {31'h0, evt_valid}, 32'h0);
        chk("fr_cnt", evt_count, 32'h1);
        drive(hw(16'h0012), 1, 1, 0); tick();
        drive({2'b11, 30'h0}, 1, 1, 0); tick();
        drive(mw(2'b01), 1, 1, 0); tick();
        drive(32'h0, 0, 1, 0);
        chk("fr2_ef", {28'h0, err_frame}, 32'h4);
        chk("fr2_valid", {31'h0, evt_valid}, 32'h0);
        chk("fr2_es", {28'h0, err_seq}, 32'h0);
        chk("fr2_cnt", evt_count, 32'h1);

        // Backpressure: ready low for 10 cycles with two records offered.
        drive(32'h0, 0, 0, 1); tick();
        drive(hw(16'h0020), 1, 0, 0);
        chk("bp_tr0", {31'h0, tready}, 32'h1);
        tick();
        drive(mw(2'b01), 1, 0, 0);
        chk("bp_tr1", {31'h0, tready}, 32'h1);
        tick();
        drive(hw(16'h0021), 1, 0, 0);
        chk("bp_tr2", {31'h0, tready}, 32'h1);
        chk("bp_v2", {31'h0, evt_valid}, 32'h1);
        tick();
        for (int k = 3; k < 10; k++) begin
            drive(mw(2'b10), 1, 0, 0);
            chk($sformatf("bp%0d_tready", k), {31'h0, tready}, 32'h0);
            chk($sformatf("bp%0d_valid", k), {31'h0, evt_valid}, 32'h1);
            chk($sformatf("bp%0d_seq", k), {16'h0, evt_seq}, 32'h20);
            chk($sformatf("bp%0d_mask", k), {30'h0, evt_mask}, 32'h1);
            tick();
        end
        drive(mw(2'b10), 1, 1, 0);
        chk("bp10_tready", {31'h0, tready}, 32'h1);
        chk("bp10_seq", {16'h0, evt_seq}, 32'h20);
        chk("bp10_cnt", evt_count, 32'h0);
        tick();
        drive(32'h0, 0, 1, 0);
        chk("bp11_valid", {31'h0, evt_valid}, 32'h1);
        chk("bp11_seq", {16'h0, evt_seq}, 32'h21);
        chk("bp11_mask", {30'h0, evt_mask}, 32'h2);
        chk("bp11_cnt", evt_count, 32'h1);
        tick();
        chk("bp12_valid", {31'h0, evt_valid}, 32'h0);
        chk("bp12_cnt", evt_count, 32'h2);
        chk("bp12_ef", {28'h0, err_frame}, 32'h0);

        // runrst between header and mask; then handshake coinciding with runrst.
        drive(hw(16'h0040), 1, 1, 0); tick();
        drive(mw(2'b01), 1, 1, 1);
        chk("rr_tready", {31'h0, tready}, 32'h0);
        tick();
        drive(32'h0, 0, 1, 0);
        chk("rr_valid", {31'h0, evt_valid}, 32'h0);
        chk("rr_cnt", evt_count, 32'h0);
        chk("rr_ef", {28'h0, err_frame}, 32'h0);
        chk("rr_tready_hi", {31'h0, tready}, 32'h1);
        tick();
        drive(hw(16'h0099), 1, 1, 0); tick();
        drive(mw(2'b01), 1, 0, 0); tick();
        drive(32'h0, 0, 1, 1);
        chk("rr2_valid", {31'h0, evt_valid}, 32'h1);
        chk("rr2_seq", {16'h0, evt_seq}, 32'h99);
        chk("rr2_es", {28'h0, err_seq}, 32'h0);
        chk("rr2_ef", {28'h0, err_frame}, 32'h0);
        tick();
        drive(32'h0, 0, 1, 0);
        chk("rr3_valid", {31'h0, evt_valid}, 32'h0);
        chk("rr3_cnt", evt_count, 32'h0);

        // Saturation of the 4-bit framing counter.
        drive(32'h0, 0, 1, 1); tick();
        for (int k = 0; k < 20; k++) begin
            drive(32'h0, 1, 1, 0);
            tick();
        end
        drive(32'h0, 0, 1, 0);
        chk("sat_ef", {28'h0, err_frame}, 32'hF);
        chk("sat_es", {28'h0, err_seq}, 32'h0);

        // Reset mid-record discards the partial record.
        drive(hw(16'h0050), 1, 1, 0); tick();
        rst = 1'b1;
        drive(mw(2'b11), 1, 1, 0);
        chk("mr_tready", {31'h0, tready}, 32'h0);
        tick();
        rst = 1'b0;
        drive(mw(2'b11), 1, 1, 0); tick();
        drive(32'h0, 0, 1, 0);
        chk("mr_valid", {31'h0, evt_valid}, 32'h0);
        chk("mr_ef", {28'h0, err_frame}, 32'h1);
        chk("mr_cnt", evt_count, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
